frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame sequencer FSM: scene wait, raypipe kick, pixel count, watchdog; FRAME_SEQ_CONT_EN enables back-to-back frames
module frame_sequencer #(
    parameter int NUM_PIXELS = 307200,
    parameter int WD_CYCLES  = 1048576
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start_btn,
    input  logic        sl_done,
    input  logic        pb_re,
    output logic        render_frame,
    output logic        rendering_done,
    output logic        busy,
    output logic [18:0] pixel_cnt,
    output logic [7:0]  frame_cnt,
    output logic        stall
);

    localparam int              WD_W     = $clog2(WD_CYCLES + 1);
    localparam logic [18:0]     LAST_PIX = 19'(NUM_PIXELS - 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(WD_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_SCENE = 3'd1,
        S_KICK       = 3'd2,
        S_RENDER     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_start_prev;
    logic            w_start_edge;
    logic            w_last_pixel;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_render_frame;
    logic            r_rendering_done;
    logic            r_busy;
    logic [18:0]     r_pixel_cnt;
    logic [7:0]      r_frame_cnt;
    logic            r_stall;
    logic            w_render_frame_nxt;
    logic            w_rendering_done_nxt;
    logic            w_busy_nxt;
`ifdef FRAME_SEQ_CONT_EN
    logic            r_stop_req;
`endif

    // History resets to 1 so a button held through reset is not seen as a press
    assign w_start_edge = start_btn & ~r_start_prev;
    assign w_last_pixel = (r_state == S_RENDER) && pb_re && (r_pixel_cnt == LAST_PIX);

    // Start button history for rising-edge detection
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_start_prev <= 1'b1;
        end else begin
            r_start_prev <= start_btn;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = S_WAIT_SCENE;
                end
            end
            S_WAIT_SCENE: begin
                if (sl_done) begin
                    w_next_state = S_KICK;
                end
            end
            S_KICK: begin
                w_next_state = S_RENDER;
            end
            S_RENDER: begin
                if (w_last_pixel) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
`ifdef FRAME_SEQ_CONT_EN
                w_next_state = r_stop_req ? S_IDLE : S_KICK;
`else
                w_next_state = S_IDLE;
`endif
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        w_render_frame_nxt   = (w_next_state == S_KICK);
        w_rendering_done_nxt = (w_next_state == S_DONE);
        w_busy_nxt           = (w_next_state != S_IDLE);
    end

    // Registered status pulses and busy flag
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_render_frame   <= 1'b0;
            r_rendering_done <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_render_frame   <= w_render_frame_nxt;
            r_rendering_done <= w_rendering_done_nxt;
            r_busy           <= w_busy_nxt;
        end
    end

    // Pixel and frame counters; a kick starts a fresh pixel count
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_pixel_cnt <= 19'd0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (w_next_state == S_KICK) begin
                r_pixel_cnt <= 19'd0;
            end else if ((r_state == S_RENDER) && pb_re) begin
                r_pixel_cnt <= r_pixel_cnt + 19'd1;
            end
            if (w_next_state == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // Watchdog: counts idle render cycles, saturates and latches stall until the next kick
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else if (w_next_state == S_KICK) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else if (r_state == S_RENDER) begin
            if (pb_re) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
                if (r_wd_cnt == WD_LAST) begin
                    r_stall <= 1'b1;
                end
            end
        end
    end

`ifdef FRAME_SEQ_CONT_EN
    // Stop request: a press during rendering ends the run after the current frame
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_stop_req <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_stop_req <= 1'b0;
        end else if ((r_state == S_RENDER) && w_start_edge) begin
            r_stop_req <= 1'b1;
        end
    end
`endif

    assign render_frame   = r_render_frame;
    assign rendering_done = r_rendering_done;
    assign busy           = r_busy;
    assign pixel_cnt      = r_pixel_cnt;
    assign frame_cnt      = r_frame_cnt;
    assign stall          = r_stall;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer with a behavioural model
module tb_frame_sequencer;

    localparam int NP = 4;
    localparam int WD = 8;

    logic        clk;
    logic        rst_b;
    logic        start_btn;
    logic        sl_done;
    logic        pb_re;
    logic        render_frame;
    logic        rendering_done;
    logic        busy;
    logic [18:0] pixel_cnt;
    logic [7:0]  frame_cnt;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    frame_sequencer #(.NUM_PIXELS(NP), .WD_CYCLES(WD)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .start_btn      (start_btn),
        .sl_done        (sl_done),
        .pb_re          (pb_re),
        .render_frame   (render_frame),
        .rendering_done (rendering_done),
        .busy           (busy),
        .pixel_cnt      (pixel_cnt),
        .frame_cnt      (frame_cnt),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the frame life cycle plus plain integer counters
    localparam int P_IDLE = 0, P_SCENE = 1, P_KICK = 2, P_RENDER = 3, P_DONE = 4;
    int m_phase, m_pix, m_frames, m_idle, m_stall, m_rf, m_rd, m_busy, m_prev, m_stop;

    task automatic m_reset();
        m_phase = P_IDLE; m_pix = 0; m_frames = 0; m_idle = 0; m_stall = 0;
        m_rf = 0; m_rd = 0; m_busy = 0; m_prev = 1; m_stop = 0;
    endtask

    task automatic m_step(input int s, input int sl, input int pb);
        int pressed;
        int old;
        pressed = (s == 1 && m_prev == 0) ? 1 : 0;
        m_prev  = s;
        old     = m_phase;
        if (old == P_IDLE && pressed == 1) m_phase = P_SCENE;
        else if (old == P_SCENE && sl == 1) m_phase = P_KICK;
        else if (old == P_KICK) m_phase = P_RENDER;
        else if (old == P_RENDER) begin
`ifdef FRAME_SEQ_CONT_EN
            if (pressed == 1) m_stop = 1;
`endif
            if (pb == 1) begin
                m_pix  = m_pix + 1;
                m_idle = 0;
                if (m_pix == NP) m_phase = P_DONE;
            end else begin
                if (m_idle < WD) m_idle = m_idle + 1;
                if (m_idle == WD) m_stall = 1;
            end
        end else if (old == P_DONE) begin
`ifdef FRAME_SEQ_CONT_EN
            m_phase = (m_stop == 1) ? P_IDLE : P_KICK;
            m_stop  = 0;
`else
            m_phase = P_IDLE;
`endif
        end
        m_rf = (m_phase == P_KICK) ? 1 : 0;
        m_rd = (m_phase == P_DONE) ? 1 : 0;
        if (m_phase == P_KICK) begin
            m_pix = 0; m_idle = 0; m_stall = 0;
        end
        if (m_phase == P_DONE) m_frames = (m_frames + 1) % 256;
        m_busy = (m_phase != P_IDLE) ? 1 : 0;
    endtask

    initial m_reset();

    // Advance the model on every active edge, or immediately on reset assertion
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) m_reset();
        else m_step(int'(start_btn), int'(sl_done), int'(pb_re));
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_render_frame",   int'(render_frame),   m_rf);
            chk("m_rendering_done", int'(rendering_done), m_rd);
            chk("m_busy",           int'(busy),           m_busy);
            chk("m_pixel_cnt",      int'(pixel_cnt),      m_pix);
            chk("m_frame_cnt",      int'(frame_cnt),      m_frames);
            chk("m_stall",          int'(stall),          m_stall);
            chk("m_pulse_overlap",  int'(render_frame & rendering_done), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0; start_btn = 1'b0; sl_done = 1'b0; pb_re = 1'b0;
        tick(); tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic wait_rf(input string name, input int budget);
        int n;
        n = 0;
        while (render_frame !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic run_one();
        int n;
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        wait_rf("run_kick", 20);
        pb_re = 1'b1;
        repeat (NP + 1) tick();
        pb_re = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("run_idle_timeout", 1, 0);
    endtask

    initial begin
        int cnt;
        int burst;
        rst_b = 1'b0; start_btn = 1'b0; sl_done = 1'b0; pb_re = 1'b0;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("rst_render_frame", int'(render_frame), 0);
        chk("rst_busy",         int'(busy),         0);
        chk("rst_pixel_cnt",    int'(pixel_cnt),    0);
        chk("rst_frame_cnt",    int'(frame_cnt),    0);
        chk("rst_stall",        int'(stall),        0);
        rst_b = 1'b1;
        tick();

        // Kick timing and a gapped 4-pixel frame
        sl_done = 1'b1; start_btn = 1'b1;
        tick();
        chk("kick_wait_busy", int'(busy), 1);
        chk("kick_wait_rf",   int'(render_frame), 0);
        tick();
        chk("kick_rf_high", int'(render_frame), 1);
        start_btn = 1'b0;
        tick();
        chk("kick_rf_low", int'(render_frame), 0);
        for (int i = 1; i <= NP; i++) begin
            pb_re = 1'b1; tick(); pb_re = 1'b0;
            chk("pix_step", int'(pixel_cnt), i);
            if (i < NP) tick();
        end
        chk("frame_rdone", int'(rendering_done), 1);
        chk("frame_cnt_1", int'(frame_cnt), 1);
        tick();
`ifdef FRAME_SEQ_CONT_EN
        chk("cont_rekick", int'(render_frame), 1);
`else
        chk("single_idle", int'(busy), 0);
`endif

        // Scene wait holds with no timeout
        do_reset();
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        cnt = 0;
        repeat (100) begin
            tick();
            if (render_frame) cnt++;
        end
        chk("scene_no_kick", cnt, 0);
        chk("scene_busy", int'(busy), 1);
        sl_done = 1'b1;
        tick();
        chk("scene_kick", int'(render_frame), 1);

        // Watchdog
        sl_done = 1'b0;
        tick();
        repeat (WD - 1) tick();
        chk("wd_before", int'(stall), 0);
        tick();
        chk("wd_set", int'(stall), 1);
        pb_re = 1'b1; tick(); pb_re = 1'b0;
        chk("wd_sticky", int'(stall), 1);
        chk("wd_pix", int'(pixel_cnt), 1);
        sl_done = 1'b1;
        pb_re = 1'b1; repeat (NP - 1) tick(); pb_re = 1'b0;
        chk("wd_done", int'(rendering_done), 1);
        chk("wd_done_stall", int'(stall), 1);
`ifdef FRAME_SEQ_CONT_EN
        tick();
`else
        tick();
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        tick();
`endif
        chk("wd_kick_rf", int'(render_frame), 1);
        chk("wd_cleared", int'(stall), 0);

        // Reset mid-frame and start held through reset release
        do_reset();
        sl_done = 1'b1;
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        tick(); tick();
        pb_re = 1'b1; tick(); tick(); pb_re = 1'b0;
        chk("mid_pix2", int'(pixel_cnt), 2);
        rst_b = 1'b0; start_btn = 1'b1;
        #1;
        chk("async_pix",  int'(pixel_cnt), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_fcnt", int'(frame_cnt), 0);
        tick(); tick();
        rst_b = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (render_frame) cnt++;
        end
        chk("held_no_kick", cnt, 0);
        chk("held_busy", int'(busy), 0);
        start_btn = 1'b0; tick();
        start_btn = 1'b1; tick(); tick();
        chk("held_rekick", int'(render_frame), 1);

        // Frame counter wrap
        do_reset();
        sl_done = 1'b1;
`ifdef FRAME_SEQ_CONT_EN
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        pb_re = 1'b1;
        cnt = 0;
        for (int n = 0; n < 3000 && cnt < 256; n++) begin
            tick();
            if (rendering_done) cnt++;
        end
        chk("wrap_frames", cnt, 256);
        chk("wrap_fcnt", int'(frame_cnt), 0);
        tick(); tick(); tick();
        chk("stop_pix1", int'(pixel_cnt), 1);
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        tick(); tick();
        chk("stop_pix4", int'(pixel_cnt), NP);
        chk("stop_rdone", int'(rendering_done), 1);
        pb_re = 1'b0;
        tick();
        chk("stop_idle", int'(busy), 0);
        chk("stop_no_kick", int'(render_frame), 0);
`else
        repeat (255) run_one();
        chk("wrap_255", int'(frame_cnt), 255);
        run_one();
        chk("wrap_0", int'(frame_cnt), 0);
`endif

        // Randomized traffic against the model
        do_reset();
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!rst_b) rst_b = 1'b1;
            else if ($urandom % 700 == 0) rst_b = 1'b0;
            if ($urandom % 8 == 0) start_btn = ~start_btn;
            sl_done = ($urandom % 4 != 0);
            if (burst > 0) begin
                pb_re = 1'b0;
                burst--;
            end else begin
                pb_re = ($urandom % 2 == 0);
                if ($urandom % 40 == 0) burst = $urandom_range(5, 12);
            end
            tick();
        end
        rst_b = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
